// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage sequencing controller
//
// Issues one read at a time to a multi-cycle instruction memory, hands the
// returned word to decode, and drives the PC write-enable / PC mux select.
// Redirects reload the PC and squash any response still in flight. HALT and
// memory timeout are terminal states left only through reset.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   mem_stall    memory cannot accept a request this cycle
//   mem_done     memory read data valid this cycle
//   dec_ready    IF/ID register can accept an instruction
//   redirect     taken branch/jump, target valid this cycle
//   halt_in      HALT decoded
//   mem_rd       read request at current PC
//   ibuf_ld      capture memory data into the fetch buffer
//   instr_valid  buffered instruction presented to IF/ID
//   en_PC        PC register write-enable
//   pc_sel       PC mux select: 1 = branch target, 0 = PC+2
//   halted       controller in HALT
//   err          sticky memory-timeout error
//   fetch_cnt    instructions accepted by decode (wraps)

module fetch_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_stall,
    input  logic             mem_done,
    input  logic             dec_ready,
    input  logic             redirect,
    input  logic             halt_in,
    output logic             mem_rd,
    output logic             ibuf_ld,
    output logic             instr_valid,
    output logic             en_PC,
    output logic             pc_sel,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam int            TW    = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT,
        S_ERR
    } state_t;

    state_t        state, state_n;
    logic          squash, squash_n;
    logic [TW-1:0] timer, timer_n;
    logic          cnt_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            squash    <= 1'b0;
            timer     <= '0;
            fetch_cnt <= '0;
        end else begin
            state  <= state_n;
            squash <= squash_n;
            timer  <= timer_n;
            if (cnt_inc) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_n     = state;
        squash_n    = squash;
        timer_n     = timer;
        cnt_inc     = 1'b0;
        mem_rd      = 1'b0;
        ibuf_ld     = 1'b0;
        instr_valid = 1'b0;
        en_PC       = 1'b0;
        pc_sel      = 1'b0;
        halted      = 1'b0;
        err         = 1'b0;

        case (state)
            S_IDLE: begin
                if (halt_in) begin
                    state_n = S_HALT;
                end else begin
                    state_n = S_REQ;
                    if (redirect) begin
                        en_PC  = 1'b1;
                        pc_sel = 1'b1;
                    end
                end
            end

            S_REQ: begin
                if (halt_in) begin
                    state_n = S_HALT;
                end else if (redirect) begin
                    // Hold the request back so it goes out with the new PC.
                    en_PC  = 1'b1;
                    pc_sel = 1'b1;
                end else begin
                    mem_rd = 1'b1;
                    if (!mem_stall) begin
                        state_n = S_WAIT;
                        timer_n = '0;
                    end
                end
            end

            S_WAIT: begin
                if (halt_in) begin
                    state_n = S_HALT;
                end else begin
                    timer_n = timer + TW'(1);
                    if (redirect) begin
                        en_PC  = 1'b1;
                        pc_sel = 1'b1;
                    end
                    if (mem_done) begin
                        // A response for a PC that has since been redirected is
                        // dropped; the next request fetches from the new target.
                        if (squash || redirect) begin
                            squash_n = 1'b0;
                        end else begin
                            ibuf_ld = 1'b1;
                        end
                        state_n = (squash || redirect) ? S_REQ : S_HOLD;
                    end else if (timer == TLAST) begin
                        state_n = S_ERR;
                    end else if (redirect) begin
                        squash_n = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (halt_in) begin
                    state_n = S_HALT;
                end else if (redirect) begin
                    en_PC   = 1'b1;
                    pc_sel  = 1'b1;
                    state_n = S_REQ;
                end else begin
                    instr_valid = 1'b1;
                    if (dec_ready) begin
                        en_PC   = 1'b1;
                        cnt_inc = 1'b1;
                        state_n = S_REQ;
                    end
                end
            end

            S_HALT: halted = 1'b1;

            S_ERR: err = 1'b1;

            default: state_n = S_ERR;
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl

module tb_fetch_ctrl;

    logic       clk;
    logic       rst;
    logic       mem_stall;
    logic       mem_done;
    logic       dec_ready;
    logic       redirect;
    logic       halt_in;
    logic       mem_rd;
    logic       ibuf_ld;
    logic       instr_valid;
    logic       en_PC;
    logic       pc_sel;
    logic       halted;
    logic       err;
    logic [3:0] fetch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_ctrl #(
        .TIMEOUT(16),
        .CNT_W  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_stall  (mem_stall),
        .mem_done   (mem_done),
        .dec_ready  (dec_ready),
        .redirect   (redirect),
        .halt_in    (halt_in),
        .mem_rd     (mem_rd),
        .ibuf_ld    (ibuf_ld),
        .instr_valid(instr_valid),
        .en_PC      (en_PC),
        .pc_sel     (pc_sel),
        .halted     (halted),
        .err        (err),
        .fetch_cnt  (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Vector order: mem_rd ibuf_ld instr_valid en_PC pc_sel halted err
    task automatic chk_out(input string tag, input logic [6:0] exp);
        chk(tag, 32'({mem_rd, ibuf_ld, instr_valid, en_PC, pc_sel, halted, err}), 32'(exp));
    endtask

    task automatic cnt_is(input string tag, input int exp);
        chk(tag, 32'(fetch_cnt), 32'(exp));
    endtask

    // One clock cycle: drive inputs at the falling edge, settle, check invariants.
    task automatic cyc(input logic s, input logic d, input logic r, input logic rd, input logic h);
        @(negedge clk);
        mem_stall = s;
        mem_done  = d;
        dec_ready = r;
        redirect  = rd;
        halt_in   = h;
        #1;
        chk("inv_rd_iv", 32'(mem_rd & instr_valid), 32'd0);
        chk("inv_enpc", 32'(en_PC & ~(redirect | (instr_valid & dec_ready))), 32'd0);
        chk("inv_pcsel", 32'(pc_sel & ~en_PC), 32'd0);
    endtask

    task automatic rst_pulse(input string tag);
        @(negedge clk);
        rst = 1'b0;
        mem_stall = 1'b0; mem_done = 1'b0; dec_ready = 1'b0; redirect = 1'b0; halt_in = 1'b0;
        #1;
        chk_out({tag, "_outs"}, 7'b0000000);
        cnt_is({tag, "_cnt"}, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_out({tag, "_idle"}, 7'b0000000);
    endtask

    initial begin
        rst = 1'b0;
        mem_stall = 1'b0; mem_done = 1'b0; dec_ready = 1'b0; redirect = 1'b0; halt_in = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_out("reset_outs", 7'b0000000);
        cnt_is("reset_cnt", 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_out("idle_outs", 7'b0000000);

        // Streaming: REQ, WAIT, WAIT+done, HOLD repeating; en_PC every 4th cycle.
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 0, 0); chk_out("stream_req", 7'b1000000); cnt_is("stream_cnt", i);
            cyc(0, 0, 1, 0, 0); chk_out("stream_wait", 7'b0000000);
            cyc(0, 1, 1, 0, 0); chk_out("stream_done", 7'b0100000);
            cyc(0, 0, 1, 0, 0); chk_out("stream_hold", 7'b0011000);
        end

        // Back-pressure: five HOLD cycles without dec_ready.
        cyc(0, 0, 0, 0, 0); chk_out("bp_req", 7'b1000000); cnt_is("stream_total", 10);
        cyc(0, 0, 0, 0, 0); chk_out("bp_wait", 7'b0000000);
        cyc(0, 1, 0, 0, 0); chk_out("bp_done", 7'b0100000);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0); chk_out("bp_hold", 7'b0010000); cnt_is("bp_cnt", 10);
        end
        cyc(0, 0, 1, 0, 0); chk_out("bp_release", 7'b0011000);

        // Redirect in REQ: request withheld, reissued next cycle.
        cyc(0, 0, 1, 1, 0); chk_out("rd_req", 7'b0001100); cnt_is("bp_cnt_after", 11);
        cyc(0, 0, 1, 0, 0); chk_out("rd_req_next", 7'b1000000);
        // Redirect in WAIT, response two cycles later is dropped.
        cyc(0, 0, 1, 1, 0); chk_out("rd_wait", 7'b0001100);
        cyc(0, 0, 1, 0, 0); chk_out("rd_wait_sq", 7'b0000000);
        cyc(0, 1, 1, 0, 0); chk_out("rd_drop", 7'b0000000);
        cyc(0, 0, 1, 0, 0); chk_out("rd_new_req", 7'b1000000); cnt_is("rd_cnt", 11);
        // Squash cleared: the next response is delivered; redirect in HOLD discards it.
        cyc(0, 0, 1, 0, 0); chk_out("rd2_wait", 7'b0000000);
        cyc(0, 1, 1, 0, 0); chk_out("rd2_done", 7'b0100000);
        cyc(0, 0, 1, 1, 0); chk_out("rd_hold", 7'b0001100);
        cyc(0, 0, 1, 0, 0); chk_out("rd_hold_req", 7'b1000000); cnt_is("rd_hold_cnt", 11);

        // Redirect and halt together in HOLD: halt wins.
        cyc(0, 0, 1, 0, 0); chk_out("h_wait", 7'b0000000);
        cyc(0, 1, 1, 0, 0); chk_out("h_done", 7'b0100000);
        cyc(0, 0, 1, 1, 1); chk_out("h_beats_rd", 7'b0000000);
        for (int i = 0; i < 20; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk_out("halt_sticky", 7'b0000010);
        end
        cnt_is("halt_cnt", 11);

        // Timeout: no mem_done after acceptance; ERR 16 cycles later.
        rst_pulse("rst_halt");
        cyc(0, 0, 1, 0, 0); chk_out("to_req", 7'b1000000);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1, 0, 0); chk_out("to_wait", 7'b0000000);
        end
        cyc(0, 0, 1, 0, 0); chk_out("to_err", 7'b0000001);
        for (int i = 0; i < 5; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk_out("err_sticky", 7'b0000001);
        end
        rst_pulse("rst_err");

        // Stall for three cycles in REQ; WAIT only once the stall drops.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 0, 0); chk_out("stall_req", 7'b1000000);
        end
        cyc(0, 0, 1, 0, 0); chk_out("stall_accept", 7'b1000000);
        cyc(0, 0, 1, 0, 0); chk_out("stall_wait", 7'b0000000);
        cyc(0, 1, 1, 0, 0); chk_out("stall_done", 7'b0100000);
        cyc(0, 0, 1, 0, 0); chk_out("stall_hold", 7'b0011000);

        // 15 more deliveries: the 4-bit counter wraps to 0.
        for (int i = 1; i < 16; i++) begin
            cyc(0, 0, 1, 0, 0); chk_out("wrap_req", 7'b1000000); cnt_is("wrap_cnt", i);
            cyc(0, 0, 1, 0, 0); chk_out("wrap_wait", 7'b0000000);
            cyc(0, 1, 1, 0, 0); chk_out("wrap_done", 7'b0100000);
            cyc(0, 0, 1, 0, 0); chk_out("wrap_hold", 7'b0011000);
        end
        cyc(0, 0, 1, 0, 0); chk_out("wrap_final_req", 7'b1000000); cnt_is("cnt_wrap", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
